double_buffer_loader: RTL and testbench
=======================================

// Module: double_buffer_loader
// PURPOSE
//   Write-side sequencer for the addressable double buffer. Accepts a valid/ready element stream,
//   writes each element into the inactive bank, zero-pads short frames, then issues swap_buffers
//   once the consumer has released the active bank. Sits between the operand stream and the VPU lanes.
// PARAMETERS
//   DATA_WIDTH   8   bits per element
//   MATRIX_SIZE  3   elements per vector (buffer depth); >=2
//   CNT_WIDTH    16  width of vec_count
// PORTS
//   clk            in   1                      clock
//   rst            in   1                      synchronous reset, active-high
//   in_valid       in   1                      stream element valid
//   in_ready       out  1                      loader can accept element
//   in_data        in   DATA_WIDTH             stream element
//   in_last        in   1                      last element of vector frame
//   consumer_ready in   1                      consumer done with active bank; swap allowed
//   err_clr        in   1                      clears frame_err
//   load_addr      out  $clog2(MATRIX_SIZE)    buffer write address
//   load_data      out  DATA_WIDTH             buffer write data
//   load_we        out  1                      buffer write enable
//   swap_buffers   out  1                      one-cycle swap pulse to buffer
//   vec_valid      out  1                      one-cycle pulse: new vector now active
//   frame_err      out  1                      sticky: in_last mismatch seen
//   vec_count      out  CNT_WIDTH              vectors swapped since reset, wraps
// BEHAVIOUR
//   Reset: state=LOAD, idx=0, vec_count=0, frame_err=0, vec_valid=0; combinational outputs follow
//     (in_ready=1, load_we=0, swap_buffers=0, load_addr=0, load_data=0). Buffer is reset on same rst.
//   States: LOAD, PAD, FULL.
//   LOAD: in_ready=1. load_we=in_valid; load_addr=idx; load_data=in_data (combinational,
//     zero latency: buffer captures on the accepting edge).
//     On accept: idx<MATRIX_SIZE-1 & !in_last -> idx++.
//     idx==MATRIX_SIZE-1 -> idx=0, ->FULL; if !in_last set frame_err (vector still completes).
//     idx<MATRIX_SIZE-1 & in_last -> set frame_err, idx++, ->PAD.
//   PAD: in_ready=0; load_we=1, load_addr=idx, load_data=0 each cycle; idx++;
//     after writing MATRIX_SIZE-1: idx=0, ->FULL. Short frame takes (MATRIX_SIZE-n) pad cycles.
//   FULL: in_ready=0, load_we=0. swap_buffers=consumer_ready (combinational);
//     on swap: ->LOAD, vec_count++ (wraps at 2^CNT_WIDTH), vec_valid=1 next cycle for exactly 1 cycle.
//   Swap and write never share a cycle; in_ready=0 whenever state!=LOAD.
//   Min period per vector: MATRIX_SIZE accept cycles + 1 swap cycle.
//   frame_err: set by mismatch, cleared by err_clr; set wins if both in same cycle.
//   in_data/in_last ignored when !in_valid or !in_ready. Stream holds data while in_ready=0.
//   Reset mid-frame: partial vector discarded, both banks zero, state LOAD, idx=0.
// TESTING
//   1. MATRIX_SIZE=3, consumer_ready=1, stream 0x11,0x22,0x33(last) back-to-back -> load_we at
//      addr 0,1,2; swap_buffers 1 cycle after 3rd accept; vec_valid next; data_out_flat=0x332211.
//   2. consumer_ready=0 after frame -> in_ready=0, no swap; raise after 10 cycles -> single swap,
//      vec_count=1, next frame accepted the cycle after swap.
//   3. Short frame 0xAA(last) -> frame_err=1, PAD writes 0 to addr 1,2; output 0x0000AA.
//   4. Long frame 0x01,0x02,0x03(no last) -> frame_err=1, vector 0x030201 swapped; err_clr -> 0.
//   5. rst after 2 of 3 elements -> idx=0, vec_count=0, in_ready=1; next 3-elem frame loads cleanly.
//   6. in_valid toggling random with consumer_ready random, 100 frames -> vec_count=100, each
//      active vector equals scoreboard, no write during swap cycle.

Source files
------------

// File: rtl/double_buffer_loader.sv
// double_buffer_loader: write-side sequencer for the addressable double buffer.
// Fills the inactive bank from a valid/ready stream, pads short frames, then swaps.
module double_buffer_loader #(
   parameter int DATA_WIDTH  = 8,
   parameter int MATRIX_SIZE = 3,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DATA_WIDTH-1:0]          in_data,
   input  logic                           in_last,
   input  logic                           consumer_ready,
   input  logic                           err_clr,
   output logic [$clog2(MATRIX_SIZE)-1:0] load_addr,
   output logic [DATA_WIDTH-1:0]          load_data,
   output logic                           load_we,
   output logic                           swap_buffers,
   output logic                           vec_valid,
   output logic                           frame_err,
   output logic [CNT_WIDTH-1:0]           vec_count
);

   localparam int AW = $clog2(MATRIX_SIZE);
   localparam logic [AW-1:0] LAST_IDX = AW'(MATRIX_SIZE - 1);

   typedef enum logic [1:0] {
      LOAD,
      PAD,
      FULL
   } state_t;

   state_t        state, state_n;
   logic [AW-1:0] idx, idx_n;
   logic          err_set;
   logic          swap;

   // Next-state, write port and swap decode for the current fill phase.
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      err_set   = 1'b0;
      swap      = 1'b0;
      in_ready  = 1'b0;
      load_we   = 1'b0;
      load_addr = idx;
      load_data = '0;
      unique case (state)
         LOAD: begin
            in_ready = 1'b1;
            load_we  = in_valid;
            if (in_valid) begin
               load_data = in_data;
               if (idx == LAST_IDX) begin
                  idx_n   = '0;
                  state_n = FULL;
                  err_set = !in_last;
               end else begin
                  idx_n = idx + AW'(1);
                  if (in_last) begin
                     err_set = 1'b1;
                     state_n = PAD;
                  end
               end
            end
         end
         PAD: begin
            load_we = 1'b1;
            if (idx == LAST_IDX) begin
               idx_n   = '0;
               state_n = FULL;
            end else begin
               idx_n = idx + AW'(1);
            end
         end
         FULL: begin
            swap = consumer_ready;
            if (consumer_ready) begin
               state_n = LOAD;
            end
         end
         default: begin
            state_n = LOAD;
            idx_n   = '0;
         end
      endcase
   end

   assign swap_buffers = swap;

   // Phase and write-index registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LOAD;
         idx   <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
      end
   end

   // Swap counter and the one-cycle new-vector pulse that trails each swap.
   always_ff @(posedge clk) begin
      if (rst) begin
         vec_count <= '0;
         vec_valid <= 1'b0;
      end else begin
         vec_valid <= swap;
         if (swap) begin
            vec_count <= vec_count + CNT_WIDTH'(1);
         end
      end
   end

   // Sticky framing error; a new mismatch outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err <= 1'b0;
      end else if (err_set) begin
         frame_err <= 1'b1;
      end else if (err_clr) begin
         frame_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_double_buffer_loader.sv
// tb_double_buffer_loader: directed and randomised frames against a
// frame-count model, a downstream buffer model and a vector scoreboard.
module tb_double_buffer_loader;

   localparam int DW = 8;
   localparam int MS = 3;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          in_last = 1'b0;
   logic          consumer_ready = 1'b0;
   logic          err_clr = 1'b0;
   logic [1:0]    load_addr;
   logic [DW-1:0] load_data;
   logic          load_we;
   logic          swap_buffers;
   logic          vec_valid;
   logic          frame_err;
   logic [CW-1:0] vec_count;

   double_buffer_loader #(
      .DATA_WIDTH (DW),
      .MATRIX_SIZE(MS),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_last       (in_last),
      .consumer_ready(consumer_ready),
      .err_clr       (err_clr),
      .load_addr     (load_addr),
      .load_data     (load_data),
      .load_we       (load_we),
      .swap_buffers  (swap_buffers),
      .vec_valid     (vec_valid),
      .frame_err     (frame_err),
      .vec_count     (vec_count)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // model: elements written into the current frame, pad phase, errors, swaps
   int  m_wcnt  = 0;
   bit  m_pad   = 1'b0;
   bit  m_err   = 1'b0;
   bit  m_vv    = 1'b0;
   int  m_swaps = 0;

   logic [DW-1:0] bank [MS];
   logic [23:0]   last_active = '0;
   logic [23:0]   exp_q [$];
   int            n_vec = 0;
   bit            rnd_cr = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t",
                    nm, act, exp, $time);
   endtask

   // per-cycle compare, downstream buffer model, then model step
   always @(negedge clk) begin : cmp_p
      bit er, ew, es, set;
      er = (m_wcnt < MS) && !m_pad;
      ew = m_pad || (er && in_valid);
      es = (m_wcnt == MS) && consumer_ready;
      chk("in_ready", 32'(in_ready), 32'(er));
      chk("load_we", 32'(load_we), 32'(ew));
      chk("swap_buffers", 32'(swap_buffers), 32'(es));
      chk("vec_valid", 32'(vec_valid), 32'(m_vv));
      chk("frame_err", 32'(frame_err), 32'(m_err));
      chk("vec_count", 32'(vec_count), 32'(16'(m_swaps)));
      if (ew) begin
         chk("load_addr", 32'(load_addr), 32'(m_wcnt));
         chk("load_data", 32'(load_data),
             m_pad ? 32'd0 : 32'(in_data));
      end
      if (rst) begin
         for (int i = 0; i < MS; i++) bank[i] = '0;
         last_active = '0;
         exp_q.delete();
         n_vec = 0;
      end else begin
         if (load_we && load_addr < 2'(MS)) bank[load_addr] = load_data;
         if (swap_buffers) begin
            last_active = {bank[2], bank[1], bank[0]};
            n_vec++;
            if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
            else chk("vector", 32'(last_active), 32'(exp_q.pop_front()));
         end
      end
      if (rst) begin
         m_wcnt = 0; m_pad = 0; m_err = 0; m_vv = 0; m_swaps = 0;
      end else begin
         set  = 1'b0;
         m_vv = es;
         if (er && in_valid) begin
            if (m_wcnt == MS - 1) begin
               set    = !in_last;
               m_wcnt = MS;
            end else begin
               m_wcnt++;
               if (in_last) begin
                  set   = 1'b1;
                  m_pad = 1'b1;
               end
            end
         end else if (m_pad) begin
            m_wcnt++;
            if (m_wcnt == MS) m_pad = 1'b0;
         end else if (es) begin
            m_wcnt = 0;
            m_swaps++;
         end
         if (set) m_err = 1'b1;
         else if (err_clr) m_err = 1'b0;
      end
   end

   task automatic do_reset(input bit cr);
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      in_data = '0; err_clr = 1'b0; consumer_ready = cr;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic send(input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input int n, input bit lst,
                       input bit gaps, input bit push);
      logic [7:0]  d [3];
      logic [23:0] ev;
      bit          a;
      d  = '{d0, d1, d2};
      ev = '0;
      for (int i = 0; i < n && i < MS; i++) ev = ev | (24'(d[i]) << (8 * i));
      if (push) exp_q.push_back(ev);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               in_data  = 8'($urandom);
               in_last  = 1'($urandom);
               @(posedge clk); #1;
            end
         end
         in_valid = 1'b1;
         in_data  = d[i];
         in_last  = lst && (i == n - 1);
         a = 1'b0;
         for (int k = 0; k < 300 && !a; k++) begin
            @(negedge clk);
            a = in_ready;
            @(posedge clk); #1;
         end
         if (!a) chk("accept_timeout", 32'd0, 32'd1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic wait_vec();
      bit got;
      got = 1'b0;
      for (int k = 0; k < 300 && !got; k++) begin
         @(negedge clk);
         got = vec_valid;
      end
      if (!got) chk("vec_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rnd_cr) consumer_ready = 1'($urandom);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit          lst;
      int          n, k;
      logic [7:0]  a0, a1, a2;

      do_reset(1'b1);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_load_we", 32'(load_we), 32'd0);
      chk("rst_swap", 32'(swap_buffers), 32'd0);
      chk("rst_addr", 32'(load_addr), 32'd0);
      chk("rst_data", 32'(load_data), 32'd0);
      chk("rst_vec_valid", 32'(vec_valid), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      chk("rst_vec_count", 32'(vec_count), 32'd0);
      @(posedge clk); #1;

      // back-to-back well-formed frame
      send(8'h11, 8'h22, 8'h33, 3, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      chk("t1_swap", 32'(swap_buffers), 32'd1);
      chk("t1_no_write", 32'(load_we), 32'd0);
      @(negedge clk);
      chk("t1_vec_valid", 32'(vec_valid), 32'd1);
      chk("t1_vec_count", 32'(vec_count), 32'd1);
      chk("t1_vector", 32'(last_active), 32'h332211);
      @(posedge clk); #1;

      // consumer holds the active bank
      do_reset(1'b0);
      send(8'h12, 8'h34, 8'h56, 3, 1'b1, 1'b0, 1'b1);
      repeat (10) begin
         @(negedge clk);
         chk("t2_hold_ready", 32'(in_ready), 32'd0);
         chk("t2_hold_swap", 32'(swap_buffers), 32'd0);
      end
      @(posedge clk); #1;
      consumer_ready = 1'b1;
      @(negedge clk);
      chk("t2_swap", 32'(swap_buffers), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 8'h77;
      @(negedge clk);
      chk("t2_count", 32'(vec_count), 32'd1);
      chk("t2_ready_after_swap", 32'(in_ready), 32'd1);
      chk("t2_we_after_swap", 32'(load_we), 32'd1);
      chk("t2_vector", 32'(last_active), 32'h563412);
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_q.push_back(24'h998877);
      send(8'h88, 8'h99, 8'h00, 2, 1'b1, 1'b0, 1'b0);
      wait_vec();
      chk("t2_vector2", 32'(last_active), 32'h998877);
      chk("t2_count2", 32'(vec_count), 32'd2);

      // short frame gets zero-padded
      send(8'hAA, 8'h00, 8'h00, 1, 1'b1, 1'b0, 1'b1);
      wait_vec();
      chk("t3_frame_err", 32'(frame_err), 32'd1);
      chk("t3_vector", 32'(last_active), 32'h0000AA);

      // clear, then long frame with clear held: set must win
      err_clr = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t4_cleared", 32'(frame_err), 32'd0);
      @(posedge clk); #1;
      send(8'h01, 8'h02, 8'h03, 3, 1'b0, 1'b0, 1'b1);
      err_clr = 1'b0;
      @(negedge clk);
      chk("t4_set_wins", 32'(frame_err), 32'd1);
      @(posedge clk); #1;
      wait_vec();
      chk("t4_vector", 32'(last_active), 32'h030201);
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      @(negedge clk);
      chk("t4_err_clr", 32'(frame_err), 32'd0);
      @(posedge clk); #1;

      // reset in the middle of a frame
      send(8'hE1, 8'hE2, 8'h00, 2, 1'b0, 1'b0, 1'b0);
      do_reset(1'b1);
      in_valid = 1'b1;
      in_data  = 8'h44;
      @(negedge clk);
      chk("t5_in_ready", 32'(in_ready), 32'd1);
      chk("t5_vec_count", 32'(vec_count), 32'd0);
      chk("t5_addr", 32'(load_addr), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_q.push_back(24'h665544);
      send(8'h55, 8'h66, 8'h00, 2, 1'b1, 1'b0, 1'b0);
      wait_vec();
      chk("t5_vector", 32'(last_active), 32'h665544);
      chk("t5_frame_err", 32'(frame_err), 32'd0);

      // random gaps and random consumer back-pressure
      do_reset(1'b0);
      rnd_cr = 1'b1;
      for (int f = 0; f < 100; f++) begin
         n   = $urandom_range(1, 3);
         lst = (n < 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
         a0  = 8'($urandom);
         a1  = 8'($urandom);
         a2  = 8'($urandom);
         send(a0, a1, a2, n, lst, 1'b1, 1'b1);
      end
      k = 0;
      while (n_vec < 100 && k < 1000) begin
         @(posedge clk); #1;
         k++;
      end
      rnd_cr = 1'b0;
      @(negedge clk);
      chk("t6_vec_count", 32'(vec_count), 32'd100);
      chk("t6_vectors", 32'(n_vec), 32'd100);
      chk("t6_sb_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
